crc_stream: RTL and testbench

Parametrised, streaming CRC generator/checker; next generation of `crc16`. Polynomial, width, reflection and output XOR are set at elaboration. Wide input beats arrive over a valid/ready handshake and are folded STEP_W bits per clock. Frames span any number of beats, with a partial final beat. Sits between the packet deserialiser and the frame-validation logic; reports CRC and a compare error per frame.

---
 rtl/crc_pkg.sv | 49 ++++
 rtl/crc_stream.sv | 154 +++++++++++++++
 tb/tb_crc_stream.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types and bit-level helpers for the streaming CRC engine.
package crc_pkg;

  localparam int unsigned MAX_W      = 32;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned BYTES      = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } crc_state_t;

  // MSB-first LFSR update; consumes bits[7], bits[6], ... for n bits.
  function automatic logic [MAX_W-1:0] crc_fold(
    input logic [MAX_W-1:0] crc,
    input logic [7:0]       bits,
    input logic [MAX_W-1:0] poly,
    input int unsigned      crc_w,
    input int unsigned      n
  );
    logic [MAX_W-1:0] c;
    logic [MAX_W-1:0] mask;
    logic             fb;
    mask = (crc_w >= MAX_W) ? '1 : ((MAX_W'(1) << crc_w) - MAX_W'(1));
    c    = crc & mask;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) begin
        fb = c[5'(crc_w - 1)] ^ bits[3'(7 - i)];
        c  = ((c << 1) & mask) ^ (fb ? (poly & mask) : '0);
      end
    end
    return c;
  endfunction

  // Bit-reverse the low w bits of vec; upper bits return zero.
  function automatic logic [MAX_W-1:0] reflect(
    input logic [MAX_W-1:0] vec,
    input int unsigned      w
  );
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[5'(i)] = vec[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream.sv
// Streaming CRC generator/checker: accepts wide beats over valid/ready and
// folds STEP_W bits per clock, reporting the CRC and a compare error per frame.
module crc_stream
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0,
  parameter logic [CRC_W-1:0] XOROUT = '0,
  parameter int unsigned      DATA_W = DEF_DATA_W,
  parameter int unsigned      STEP_W = 8,
  localparam int unsigned     NB     = DATA_W / 8,
  localparam int unsigned     NBW    = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initialize,
  input  logic [CRC_W-1:0]  crc_init,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [NBW-1:0]    din_nbytes,
  input  logic              din_last,
  input  logic [CRC_W-1:0]  crc_exp,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err,
  output logic              busy
);

  localparam int unsigned MAXK = DATA_W / STEP_W;
  localparam int unsigned CNTW = $clog2(MAXK + 1);

  crc_state_t        state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  exp_q, exp_d;
  logic [CRC_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0] beat_q, beat_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] din_ord;
  logic [NBW-1:0]    nb_eff;
  logic [CNTW-1:0]   k_steps;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  fin_out;

  // Ready depends on initialize combinationally so a same-cycle abort wins.
  assign din_ready = (state_q == S_IDLE) && !initialize && !rst;

  // Reflected input: swap bit order inside each byte so shifting MSB-first eats LSBs first.
  always_comb begin
    din_ord = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        din_ord[b*8 + i] = REFIN ? din[b*8 + 7 - i] : din[b*8 + i];
      end
    end
  end

  assign nb_eff   = (din_nbytes == '0 || din_nbytes > NBW'(NB)) ? NBW'(NB) : din_nbytes;
  assign k_steps  = CNTW'((32'(nb_eff) * 32'd8) / STEP_W);
  assign crc_next = CRC_W'(crc_fold(MAX_W'(crc_q), beat_q[DATA_W-1 -: 8], MAX_W'(POLY),
                                    CRC_W, STEP_W));
  assign fin_out  = (REFOUT ? CRC_W'(reflect(MAX_W'(crc_next), CRC_W)) : crc_next) ^ XOROUT;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    exp_d   = exp_q;
    out_d   = out_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          beat_d  = din_ord;
          cnt_d   = k_steps;
          last_d  = din_last;
          exp_d   = crc_exp;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        crc_d  = crc_next;
        beat_d = beat_q << STEP_W;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q <= CNTW'(1)) begin
          if (last_q) begin
            state_d = S_DONE;
            out_d   = fin_out;
            err_d   = (fin_out != exp_q);
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        crc_d   = crc_init;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (initialize) begin
      state_d = S_IDLE;
      crc_d   = crc_init;
      valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q   <= crc_init;
      exp_q   <= '0;
      out_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign crc_valid = valid_q;
  assign crc_out   = out_q;
  assign crc_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: CRC-16/CCITT, CRC-32 and bit-serial variants
// driven with "123456789" split across beats, plus handshake and abort corners.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        init0, init32, init1;
  logic [15:0] crc_init16, exp16;
  logic [31:0] crc_init32, exp32;
  logic        din_valid;
  logic [63:0] din;
  logic [$clog2(crc_pkg::BYTES):0] din_nbytes;
  logic        din_last;

  logic        r0, v0, e0, b0;
  logic [15:0] o0;
  logic        r32, v32, e32, b32;
  logic [31:0] o32;
  logic        r1, v1, e1, b1;
  logic [15:0] o1;

  int checks = 0;
  int errors = 0;
  int acc0   = 0;

  int          m_busy, m_valid_at, m_valid_n, m_rlow;
  logic [31:0] m_res;
  logic        m_err, m_rdy_after;

  localparam logic [63:0] D1 = 64'h3132333435363738;
  localparam logic [63:0] D2 = 64'h3900000000000000;

  always #5 clk = ~clk;

  crc_stream u_dut0 (
    .clk(clk), .rst(rst), .initialize(init0), .crc_init(crc_init16),
    .din_valid(din_valid), .din_ready(r0), .din(din), .din_nbytes(din_nbytes),
    .din_last(din_last), .crc_exp(exp16), .crc_valid(v0), .crc_out(o0),
    .crc_err(e0), .busy(b0));

  crc_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .REFIN(1'b1), .REFOUT(1'b1),
               .XOROUT(32'hFFFFFFFF)) u_dut32 (
    .clk(clk), .rst(rst), .initialize(init32), .crc_init(crc_init32),
    .din_valid(din_valid), .din_ready(r32), .din(din), .din_nbytes(din_nbytes),
    .din_last(din_last), .crc_exp(exp32), .crc_valid(v32), .crc_out(o32),
    .crc_err(e32), .busy(b32));

  crc_stream #(.STEP_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .initialize(init1), .crc_init(crc_init16),
    .din_valid(din_valid), .din_ready(r1), .din(din), .din_nbytes(din_nbytes),
    .din_last(din_last), .crc_exp(exp16), .crc_valid(v1), .crc_out(o1),
    .crc_err(e1), .busy(b1));

  // Accept events on the default instance; inputs only change just after posedge.
  always @(negedge clk) if (din_valid && r0) acc0 <= acc0 + 1;

  function automatic logic rdy(input int s);
    return (s == 0) ? r0 : (s == 1) ? r32 : r1;
  endfunction
  function automatic logic vld(input int s);
    return (s == 0) ? v0 : (s == 1) ? v32 : v1;
  endfunction
  function automatic logic bsy(input int s);
    return (s == 0) ? b0 : (s == 1) ? b32 : b1;
  endfunction
  function automatic logic errf(input int s);
    return (s == 0) ? e0 : (s == 1) ? e32 : e1;
  endfunction
  function automatic logic [31:0] outf(input int s);
    return (s == 0) ? 32'(o0) : (s == 1) ? o32 : 32'(o1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Seed the selected instance; the others stay parked in initialize.
  task automatic start_frame(input int s, input logic [31:0] seed);
    crc_init16 = seed[15:0];
    crc_init32 = seed;
    init0 = 1'b1; init32 = 1'b1; init1 = 1'b1;
    @(posedge clk); #1;
    init0  = (s != 0);
    init32 = (s != 1);
    init1  = (s != 2);
  endtask

  task automatic send(input int s, input logic [63:0] d, input logic [3:0] nb,
                      input logic last, input logic [31:0] exp, input bit drop);
    bit ok;
    ok = 1'b0;
    din = d; din_nbytes = nb; din_last = last;
    exp16 = exp[15:0]; exp32 = exp;
    din_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rdy(s)) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    if (drop) din_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  // Called just after an accepting edge; cycle 1 is the first negedge.
  task automatic measure(input int s);
    bit done;
    done = 1'b0;
    m_busy = 0; m_valid_at = 0; m_valid_n = 0; m_rlow = 0;
    m_res = '0; m_err = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bsy(s)) begin
        m_busy++;
        if (!rdy(s)) m_rlow++;
        if (vld(s)) begin
          m_valid_n++;
          m_valid_at = m_busy;
          m_res = outf(s);
          m_err = errf(s);
        end
      end else begin
        done = 1'b1;
      end
    end
    m_rdy_after = rdy(s);
    check("measure_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic count_valid(input int s, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (vld(s)) n++;
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] seed;
    logic [63:0] d1;
    logic [3:0]  nb1;
    logic [63:0] d2;
    logic [3:0]  nb2;
    logic [31:0] exp;
    logic [31:0] out;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int base;

    vecs[0] = '{0, 32'h0000FFFF, D1, 4'd8, D2, 4'd1, 32'h29B1, 32'h29B1, 1'b0};
    vecs[1] = '{0, 32'h0000FFFF, D1, 4'd8, D2, 4'd1, 32'h29B0, 32'h29B1, 1'b1};
    vecs[2] = '{0, 32'h0000FFFF, D1, 4'd0, 64'h39FFEEDDCCBBAA99, 4'd1, 32'h29B1, 32'h29B1, 1'b0};
    vecs[3] = '{0, 32'h0000FFFF, D1, 4'd9, D2, 4'd1, 32'h29B1, 32'h29B1, 1'b0};
    vecs[4] = '{0, 32'h0000FFFF, 64'h31323334DEADBEEF, 4'd4, 64'h3536373839AABBCC, 4'd5,
                32'h29B1, 32'h29B1, 1'b0};
    vecs[5] = '{1, 32'hFFFFFFFF, D1, 4'd8, D2, 4'd1, 32'hCBF43926, 32'hCBF43926, 1'b0};
    vecs[6] = '{1, 32'hFFFFFFFF, 64'h31323334DEADBEEF, 4'd4, 64'h3536373839AABBCC, 4'd5,
                32'h0, 32'hCBF43926, 1'b1};

    rst = 1'b1; init0 = 1'b0; init32 = 1'b1; init1 = 1'b1;
    crc_init16 = 16'hFFFF; crc_init32 = 32'hFFFFFFFF;
    exp16 = '0; exp32 = '0; din_valid = 1'b0; din = '0; din_nbytes = '0; din_last = 1'b0;

    // Reset values, then ready in the first cycle after rst falls.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(r0), 32'd0);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_out",   32'(o0), 32'd0);
    check("rst_err",   32'(e0), 32'd0);
    check("rst_busy",  32'(b0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(r0), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i].sel, vecs[i].seed);
      send(vecs[i].sel, vecs[i].d1, vecs[i].nb1, 1'b0, 32'h0, 1'b1);
      measure(vecs[i].sel);
      send(vecs[i].sel, vecs[i].d2, vecs[i].nb2, 1'b1, vecs[i].exp, 1'b1);
      measure(vecs[i].sel);
      check($sformatf("vec%0d_out", i), m_res, vecs[i].out);
      check($sformatf("vec%0d_err", i), 32'(m_err), 32'(vecs[i].err));
      check($sformatf("vec%0d_nvalid", i), 32'(m_valid_n), 32'd1);
    end

    // Last full beat: ready low 9 cycles, crc_valid only in the 9th.
    start_frame(0, 32'hFFFF);
    send(0, D1, 4'd8, 1'b1, 32'h0, 1'b1);
    measure(0);
    check("tim_ready_low", 32'(m_rlow), 32'd9);
    check("tim_busy", 32'(m_busy), 32'd9);
    check("tim_valid_at", 32'(m_valid_at), 32'd9);
    check("tim_valid_n", 32'(m_valid_n), 32'd1);
    check("tim_ready_after", 32'(m_rdy_after), 32'd1);

    // din_valid held across beats: exactly two accepts.
    start_frame(0, 32'hFFFF);
    base = acc0;
    send(0, D1, 4'd8, 1'b0, 32'h0, 1'b0);
    send(0, D2, 4'd1, 1'b1, 32'h29B1, 1'b1);
    measure(0);
    check("held_out", m_res, 32'h29B1);
    check("held_accepts", 32'(acc0 - base), 32'd2);

    // Bit-serial instance: 64 steps then 8 steps.
    start_frame(2, 32'h0000);
    send(2, D1, 4'd8, 1'b0, 32'h0, 1'b1);
    measure(2);
    check("s1_busy_b1", 32'(m_busy), 32'd64);
    check("s1_rlow_b1", 32'(m_rlow), 32'd64);
    check("s1_nvalid_b1", 32'(m_valid_n), 32'd0);
    send(2, D2, 4'd1, 1'b1, 32'h31C3, 1'b1);
    measure(2);
    check("s1_busy_b2", 32'(m_busy - m_valid_n), 32'd8);
    check("s1_valid_at", 32'(m_valid_at), 32'd9);
    check("s1_out", m_res, 32'h31C3);
    check("s1_err", 32'(m_err), 32'd0);

    // initialize during the 4th BUSY cycle aborts the frame.
    start_frame(0, 32'hFFFF);
    send(0, D1, 4'd8, 1'b0, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    init0 = 1'b1;
    @(posedge clk); #1;
    init0 = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(b0), 32'd0);
    check("abort_ready", 32'(r0), 32'd1);
    count_valid(0, 12, n);
    check("abort_no_valid", 32'(n), 32'd0);
    @(posedge clk); #1;
    send(0, D1, 4'd8, 1'b0, 32'h0, 1'b1);
    measure(0);
    send(0, D2, 4'd1, 1'b1, 32'h29B1, 1'b1);
    measure(0);
    check("rerun_out", m_res, 32'h29B1);
    check("rerun_err", 32'(m_err), 32'd0);

    // initialize beats a simultaneous din_valid in IDLE.
    init0 = 1'b1; din_valid = 1'b1; din = D1; din_nbytes = 4'd8; din_last = 1'b1;
    @(negedge clk);
    check("init_blocks_ready", 32'(r0), 32'd0);
    @(posedge clk); #1;
    init0 = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    check("init_no_accept", 32'(b0), 32'd0);
    @(posedge clk); #1;

    // rst while a last beat is in BUSY.
    send(0, D1, 4'd8, 1'b1, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_ready", 32'(r0), 32'd0);
    check("mid_rst_valid", 32'(v0), 32'd0);
    check("mid_rst_out",   32'(o0), 32'd0);
    check("mid_rst_err",   32'(e0), 32'd0);
    check("mid_rst_busy",  32'(b0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_valid(0, 12, n);
    check("mid_rst_no_valid", 32'(n), 32'd0);
    @(posedge clk); #1;
    send(0, D1, 4'd8, 1'b0, 32'h0, 1'b1);
    measure(0);
    send(0, D2, 4'd1, 1'b1, 32'h29B1, 1'b1);
    measure(0);
    check("post_rst_out", m_res, 32'h29B1);
    check("post_rst_err", 32'(m_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
